cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 3, instruction opcode from the instruction register; sampled in phases 4-7.
REQ-004 SHALL have port zero, input, 1, accumulator-zero flag from the ALU.
REQ-005 SHALL have port mem_ready, input, 1, memory ready; present only when SEQ_WAIT_EN is defined.
REQ-006 SHALL have output ports sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, each 1 bit: address-mux select (1=PC), memory read, load IR, increment PC, load PC, load accumulator, memory write, and data-bus drive enable.
REQ-007 SHALL have output port halt, 1, high while the CPU is halted.
REQ-008 SHALL have output port phase, 3, current sequencer phase.

Function
REQ-009 SHALL hold a 3-bit phase counter that advances 0->1->...->7->0, one step per clk, unless halted or waiting.
REQ-010 SHALL decode opcode as HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; ALUOP = ADD|AND|XOR|LDA.
REQ-011 SHALL drive the control outputs combinationally from phase, opcode and zero, with every output not listed for a phase held at 0.
REQ-012 Phase 0 (INST_ADDR): sel=1.
REQ-013 Phase 1 (INST_FETCH): sel=1, rd=1.
REQ-014 Phases 2 (INST_LOAD) and 3 (IDLE): sel=1, rd=1, ld_ir=1.
REQ-015 Phase 4 (OP_ADDR): inc_pc=1; halt=1 when opcode=HLT.
REQ-016 Phase 5 (OP_FETCH): rd=ALUOP.
REQ-017 Phase 6 (ALU_OP): rd=ALUOP, inc_pc=(SKZ&zero), ld_pc=JMP, data_e=STO.
REQ-018 Phase 7 (STORE): rd=ALUOP, inc_pc=JMP, ld_pc=JMP, ld_ac=ALUOP, wr=STO, data_e=STO.
REQ-019 SHALL set a sticky halted flag on the clk edge that ends phase 4 when opcode=HLT; phase then holds at 5.
REQ-020 While halted: phase frozen, halt=1, and all other control outputs 0.
REQ-021 Halted flag SHALL clear only on reset; no other input leaves the halted state.
REQ-022 Phase 7 -> 0 wrap SHALL be unconditional when not waiting; a full instruction takes exactly 8 cycles when no wait occurs.
REQ-023 wr and rd SHALL never be high in the same cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force phase=0 and halted=0.
REQ-025 While rst_n is low, all control outputs SHALL be 0, including sel; halt SHALL be 0.
REQ-026 Reset asserted mid-instruction SHALL abandon the instruction; after release the first edge advances phase 0->1.

Configuration
REQ-027 Macro SEQ_WAIT_EN defined: mem_ready port exists; in phases 1 and 5, the phase SHALL hold while mem_ready=0 and advance on the first edge with mem_ready=1, with outputs held at their phase values throughout the wait.
REQ-028 Macro SEQ_WAIT_EN undefined: mem_ready port is absent and the phase advances unconditionally.
REQ-029 mem_ready SHALL be ignored in every other phase and while halted.

Verification
REQ-030 Reset release, opcode=ADD, 16 clks -> phase sequence 0..7,0..7; ld_ac=1 only in phase 7; rd=1 in phases 1,2,3,5,6,7.
REQ-031 opcode=SKZ, zero=1 -> inc_pc=1 in phases 4 and 6; repeat with zero=0 -> inc_pc=1 in phase 4 only.
REQ-032 opcode=STO -> data_e=1 in phases 6 and 7, wr=1 in phase 7 only, rd=0 in phases 5-7.
REQ-033 opcode=HLT -> halt=1 from phase 4; phase stays 5 for 20 clks; rst_n pulse -> phase=0, halt=0.
REQ-034 SEQ_WAIT_EN, mem_ready=0 for 3 clks in phase 1 -> phase stays 1 for 4 cycles with sel=1, rd=1; total instruction length is 11 cycles.
REQ-035 rst_n asserted asynchronously during phase 6 of JMP -> ld_pc drops immediately and phase=0 before the next clk.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer: phase counter, sticky halt, and combinational control decode.
// Optional macro SEQ_WAIT_EN adds mem_ready, which stretches the two memory-fetch phases (1 and 5).
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef SEQ_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   stall;
    logic   is_aluop, is_sto, is_jmp, is_skz;

    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto   = (opcode == OP_STO);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_skz   = (opcode == OP_SKZ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        stall    = 1'b0;
`ifdef SEQ_WAIT_EN
        stall    = ((phase_q == INST_FETCH) || (phase_q == OP_FETCH)) && !mem_ready;
`endif
        if (!halted_q) begin
            // HLT is recognised as phase 4 ends; the counter parks on phase 5 for good.
            if ((phase_q == OP_ADDR) && (opcode == OP_HLT)) begin
                halted_d = 1'b1;
                phase_d  = OP_FETCH;
            end else if (!stall) begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    // Reset gates the decode directly so every strobe, sel included, is low while rst_n is low.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (rst_n) begin
            if (halted_q) begin
                halt = 1'b1;
            end else begin
                case (phase_q)
                    INST_ADDR: sel = 1'b1;
                    INST_FETCH: begin
                        sel = 1'b1;
                        rd  = 1'b1;
                    end
                    INST_LOAD, IDLE: begin
                        sel   = 1'b1;
                        rd    = 1'b1;
                        ld_ir = 1'b1;
                    end
                    OP_ADDR: begin
                        inc_pc = 1'b1;
                        halt   = (opcode == OP_HLT);
                    end
                    OP_FETCH: rd = is_aluop;
                    ALU_OP: begin
                        rd     = is_aluop;
                        inc_pc = is_skz && zero;
                        ld_pc  = is_jmp;
                        data_e = is_sto;
                    end
                    STORE: begin
                        rd     = is_aluop;
                        inc_pc = is_jmp;
                        ld_pc  = is_jmp;
                        ld_ac  = is_aluop;
                        wr     = is_sto;
                        data_e = is_sto;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a rule-level model checked on every falling edge plus literal per-instruction masks.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = 3'd2;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_fail = 0;

`ifdef SEQ_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    cpu_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .zero(zero),
`ifdef SEQ_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .sel(sel),
        .rd(rd),
        .ld_ir(ld_ir),
        .inc_pc(inc_pc),
        .ld_pc(ld_pc),
        .ld_ac(ld_ac),
        .wr(wr),
        .data_e(data_e),
        .halt(halt),
        .phase(phase)
    );

    always #5 clk = ~clk;

    // Model state: which step of the instruction we are in, and whether the CPU has stopped.
    int m_phase = 0;
    bit m_halted = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) begin
                m_halted <= 1'b1;
                m_phase  <= 5;
            end else if (!(WAIT_EN && (m_phase == 1 || m_phase == 5) && !mem_ready)) begin
                m_phase <= (m_phase + 1) % 8;
            end
        end
    end

    function automatic logic [11:0] expected(int ph, logic [2:0] op, logic z, bit hlt, logic rn);
        bit alu, sto, jmp, skz;
        bit e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
        logic [2:0] p;
        p = 3'(ph);
        if (!rn) return 12'd0;
        if (hlt) return {p, 1'b1, 8'd0};
        alu    = (op >= 3'd2) && (op <= 3'd5);
        sto    = (op == 3'd6);
        jmp    = (op == 3'd7);
        skz    = (op == 3'd1);
        e_sel  = (ph <= 3);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        e_ldir = (ph == 2 || ph == 3);
        e_inc  = (ph == 4) || (ph == 6 && skz && z) || (ph == 7 && jmp);
        e_ldpc = (ph >= 6) && jmp;
        e_ldac = (ph == 7) && alu;
        e_wr   = (ph == 7) && sto;
        e_de   = (ph >= 6) && sto;
        e_halt = (ph == 4) && (op == 3'd0);
        return {p, e_halt, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de};
    endfunction

    wire [11:0] dut_vec = {phase, halt, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};

    always @(negedge clk) begin
        logic [11:0] exp_vec;
        exp_vec = expected(m_phase, opcode, zero, m_halted, rst_n);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL model t=%0t got=%b want=%b (phase,halt,sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e)",
                     $time, dut_vec, exp_vec);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    logic [23:0] seq;
    logic [7:0]  m_rd, m_ldac, m_inc, m_wr, m_de;

    // Called at posedge+2 with phase 0 current; returns at posedge+2 with phase 0 current again.
    task automatic run_instr(input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        seq = '0; m_rd = '0; m_ldac = '0; m_inc = '0; m_wr = '0; m_de = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seq[3*i +: 3] = phase;
            m_rd[i]   = rd;
            m_ldac[i] = ld_ac;
            m_inc[i]  = inc_pc;
            m_wr[i]   = wr;
            m_de[i]   = data_e;
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {23'd0, dut_vec[8:0]}, 32'd0);
        check("reset_phase", {29'd0, phase}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_instr(3'd2, 1'b0);
        check("add1_phase_seq", {8'd0, seq}, {8'd0, 24'b111_110_101_100_011_010_001_000});
        check("add1_rd_mask", {24'd0, m_rd}, 32'hEE);
        check("add1_ldac_mask", {24'd0, m_ldac}, 32'h80);
        run_instr(3'd2, 1'b1);
        check("add2_phase_seq", {8'd0, seq}, {8'd0, 24'b111_110_101_100_011_010_001_000});
        check("add2_ldac_mask", {24'd0, m_ldac}, 32'h80);

        run_instr(3'd1, 1'b1);
        check("skz_z1_inc_mask", {24'd0, m_inc}, 32'h50);
        run_instr(3'd1, 1'b0);
        check("skz_z0_inc_mask", {24'd0, m_inc}, 32'h10);

        run_instr(3'd6, 1'b0);
        check("sto_de_mask", {24'd0, m_de}, 32'hC0);
        check("sto_wr_mask", {24'd0, m_wr}, 32'h80);
        check("sto_rd_mask", {24'd0, m_rd}, 32'h0E);

        run_instr(3'd7, 1'b0);
        check("jmp_inc_mask", {24'd0, m_inc}, 32'h90);

        // HLT: run up to phase 4, then the counter must freeze on 5.
        opcode = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) check("hlt_halt_in_ph4", {31'd0, halt}, 32'd1);
            @(posedge clk);
            #2;
        end
        for (int i = 0; i < 20; i++) begin
            opcode    = 3'($urandom_range(0, 7));
            zero      = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("halted_state_%0d", i), {28'd0, phase, halt}, {28'd0, 3'd5, 1'b1});
            @(posedge clk);
            #2;
        end
        rst_n = 1'b0;
        #1;
        check("hlt_reset_phase", {29'd0, phase}, 32'd0);
        check("hlt_reset_halt", {31'd0, halt}, 32'd0);
        @(posedge clk);
        #2;
        opcode    = 3'd2;
        mem_ready = 1'b1;
        rst_n     = 1'b1;
        run_instr(3'd2, 1'b0);
        check("after_hlt_phase_seq", {8'd0, seq}, {8'd0, 24'b111_110_101_100_011_010_001_000});

        // JMP with reset asserted asynchronously inside phase 6.
        opcode = 3'd7;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) begin
                @(posedge clk);
                #2;
            end
        end
        #2;
        check("jmp_ldpc_ph6", {31'd0, ld_pc}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("jmp_async_ldpc", {31'd0, ld_pc}, 32'd0);
        check("jmp_async_phase", {29'd0, phase}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

`ifdef SEQ_WAIT_EN
        begin
            int cyc = 0;
            int ph1 = 0;
            int zeros_left = 3;
            bit done = 1'b0;
            opcode = 3'd2;
            mem_ready = 1'b1;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                cyc++;
                if (phase == 3'd1) begin
                    ph1++;
                    check($sformatf("wait_sel_rd_%0d", ph1), {30'd0, sel, rd}, 32'd3);
                end
                @(posedge clk);
                #2;
                if (phase == 3'd1 && zeros_left > 0) begin
                    mem_ready = 1'b0;
                    zeros_left--;
                end else begin
                    mem_ready = 1'b1;
                end
                if (phase == 3'd0) done = 1'b1;
            end
            check("wait_done", {31'd0, done}, 32'd1);
            check("wait_ph1_cycles", ph1, 32'd4);
            check("wait_total_cycles", cyc, 32'd11);
        end
`endif

        run_instr(3'd5, 1'b0);
        check("lda_ldac_mask", {24'd0, m_ldac}, 32'h80);
        check("lda_rd_mask", {24'd0, m_rd}, 32'hEE);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
